// File: rtl/inst_rom_loader.sv
// Boot loader and instruction RAM: receives a framed program image over a byte stream and serves fetches.
// Optional LOADER_TIMEOUT_EN adds an inter-byte timeout that aborts a stalled frame into ERR.
module inst_rom_loader #(
  parameter int DEPTH_LOG2     = 12,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        rx_ready_o,
  input  logic [31:0] inst_addr_i,
  output logic [31:0] inst_o,
  output logic        cpu_rst_o,
  output logic        load_done_o,
  output logic        load_err_o
);

  localparam logic [2:0]  S_IDLE   = 3'd0;
  localparam logic [2:0]  S_LEN_LO = 3'd1;
  localparam logic [2:0]  S_LEN_HI = 3'd2;
  localparam logic [2:0]  S_DATA   = 3'd3;
  localparam logic [2:0]  S_CSUM   = 3'd4;
  localparam logic [2:0]  S_DONE   = 3'd5;
  localparam logic [2:0]  S_ERR    = 3'd6;
  localparam logic [7:0]  MAGIC    = 8'hA5;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [16:0] MAX_WORDS = 17'(32'd1 << DEPTH_LOG2);

  logic [31:0] mem_q [2**DEPTH_LOG2];

  logic [2:0]  state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [15:0] word_idx_q, word_idx_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [7:0]  acc_q, acc_d;
  logic [23:0] asm_q, asm_d;
  logic        cpu_rst_q, load_done_q, load_err_q;
  logic        accept_s;
  logic        tmo_hit_s;
  logic        mem_we_s;
  logic [31:0] mem_wdata_s;
  logic [31:0] inst_s;
  logic        unused_s;

  assign rx_ready_o  = (state_q != S_DONE);
  assign accept_s    = rx_valid_i && rx_ready_o;
  assign cpu_rst_o   = cpu_rst_q;
  assign load_done_o = load_done_q;
  assign load_err_o  = load_err_q;
  assign inst_o      = inst_s;
  assign unused_s    = ^inst_addr_i[1:0];

`ifdef LOADER_TIMEOUT_EN
  logic [31:0] tmo_q, tmo_d;
  logic        tmo_active_s;

  assign tmo_active_s = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                        (state_q == S_DATA)   || (state_q == S_CSUM);
  assign tmo_hit_s    = tmo_active_s && !accept_s && (tmo_q == 32'(TIMEOUT_CYCLES - 1));

  // Idle-cycle counter, restarted by every accepted byte
  always_comb begin
    tmo_d = tmo_q;
    if (accept_s || !tmo_active_s) begin
      tmo_d = 32'd0;
    end else begin
      tmo_d = tmo_q + 32'd1;
    end
  end

  // Timeout counter register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_q <= 32'd0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign tmo_hit_s = 1'b0;
`endif

  // Frame parser next-state logic
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    word_idx_d  = word_idx_q;
    byte_idx_d  = byte_idx_q;
    acc_d       = acc_q;
    asm_d       = asm_q;
    mem_we_s    = 1'b0;
    mem_wdata_s = {rx_data_i, asm_q};
    if (accept_s) begin
      case (state_q)
        S_IDLE: begin
          if (rx_data_i == MAGIC) begin
            state_d = S_LEN_LO;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_LEN_LO: begin
          count_d[7:0] = rx_data_i;
          state_d      = S_LEN_HI;
        end
        S_LEN_HI: begin
          count_d[15:8] = rx_data_i;
          word_idx_d    = 16'd0;
          byte_idx_d    = 2'd0;
          acc_d         = 8'd0;
          if (({rx_data_i, count_q[7:0]} == 16'd0) ||
              ({1'b0, rx_data_i, count_q[7:0]} > MAX_WORDS)) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          // Bytes arrive LSB first, so each new byte enters at the top of the shift register
          acc_d      = acc_q ^ rx_data_i;
          asm_d      = {rx_data_i, asm_q[23:8]};
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            mem_we_s   = 1'b1;
            word_idx_d = word_idx_q + 16'd1;
            if (word_idx_q == (count_q - 16'd1)) begin
              state_d = S_CSUM;
            end else begin
              state_d = S_DATA;
            end
          end else begin
            state_d = S_DATA;
          end
        end
        S_CSUM: begin
          if (rx_data_i == acc_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ERR;
          end
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        S_ERR: begin
          if (rx_data_i == MAGIC) begin
            state_d = S_LEN_LO;
          end else begin
            state_d = S_ERR;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end else if (tmo_hit_s) begin
      state_d = S_ERR;
    end else begin
      state_d = state_q;
    end
  end

  // Parser state and status registers; status flags track the next state so they move on the same edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      count_q     <= 16'd0;
      word_idx_q  <= 16'd0;
      byte_idx_q  <= 2'd0;
      acc_q       <= 8'd0;
      asm_q       <= 24'd0;
      cpu_rst_q   <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      word_idx_q  <= word_idx_d;
      byte_idx_q  <= byte_idx_d;
      acc_q       <= acc_d;
      asm_q       <= asm_d;
      cpu_rst_q   <= (state_d == S_DONE);
      load_done_q <= (state_d == S_DONE);
      load_err_q  <= (state_d == S_ERR);
    end
  end

  // Instruction RAM write port; contents intentionally survive reset
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[word_idx_q[DEPTH_LOG2-1:0]] <= mem_wdata_s;
    end
  end

  // Combinational fetch port
  always_comb begin
    inst_s = NOP;
    if ((state_q == S_DONE) && !(|inst_addr_i[31:DEPTH_LOG2+2])) begin
      inst_s = mem_q[inst_addr_i[DEPTH_LOG2+1:2]];
    end else begin
      inst_s = NOP;
    end
  end

endmodule

// File: tb/tb_inst_rom_loader.sv
// Self-checking bench for inst_rom_loader: frames are driven byte by byte, expected fetches
// are queued as words are sent and compared against the fetch port once the load completes.
module tb_inst_rom_loader;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_valid_i;
  logic [7:0]  rx_data_i;
  logic        rx_ready_o;
  logic [31:0] inst_addr_i;
  logic [31:0] inst_o;
  logic        cpu_rst_o;
  logic        load_done_o;
  logic        load_err_o;

  int n_cmp = 0;
  int n_mis = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } sb_t;

  sb_t         sb_q[$];
  logic [31:0] img_q[$];

  inst_rom_loader #(.DEPTH_LOG2(12), .TIMEOUT_CYCLES(16)) dut (
    .clk         (clk),
    .rst         (rst_n),
    .rx_valid_i  (rx_valid_i),
    .rx_data_i   (rx_data_i),
    .rx_ready_o  (rx_ready_o),
    .inst_addr_i (inst_addr_i),
    .inst_o      (inst_o),
    .cpu_rst_o   (cpu_rst_o),
    .load_done_o (load_done_o),
    .load_err_o  (load_err_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_mis++;
      $display("FAIL %s: observed %08h expected %08h", tag, obs, expv);
    end
  endtask

  task automatic sb_push(input logic [31:0] addr, input logic [31:0] data);
    sb_t e;
    e.addr = addr;
    e.data = data;
    sb_q.push_back(e);
  endtask

  // Entered and left just after a rising edge.
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int  gap;
    bit  ok;
    logic rdy;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      rdy = rx_ready_o;
      @(posedge clk);
      #1;
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    rx_valid_i = 1'b0;
    if (!ok) check_eq("rx_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_frame(input bit with_magic, input logic [7:0] csum_flip,
                            input int max_gap, input bit expect_ok);
    logic [15:0] n;
    logic [7:0]  acc;
    logic [31:0] w;
    n   = 16'(img_q.size());
    acc = 8'h00;
    if (with_magic) send_byte(8'hA5, max_gap);
    send_byte(n[7:0], max_gap);
    send_byte(n[15:8], max_gap);
    foreach (img_q[i]) begin
      w = img_q[i];
      for (int k = 0; k < 4; k++) begin
        send_byte(w[8*k +: 8], max_gap);
        acc = acc ^ w[8*k +: 8];
      end
      if (expect_ok) sb_push(32'(i * 4), w);
    end
    send_byte(acc ^ csum_flip, max_gap);
  endtask

  task automatic check_status(input string tag, input logic rdy, input logic crst,
                              input logic dn, input logic er);
    @(negedge clk);
    check_eq({tag, ".rx_ready"},  32'(rx_ready_o),  32'(rdy));
    check_eq({tag, ".cpu_rst"},   32'(cpu_rst_o),   32'(crst));
    check_eq({tag, ".load_done"}, 32'(load_done_o), 32'(dn));
    check_eq({tag, ".load_err"},  32'(load_err_o),  32'(er));
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    sb_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      inst_addr_i = e.addr;
      #1;
      check_eq({tag, ".fetch"}, inst_o, e.data);
    end
    inst_addr_i = 32'd0;
    @(posedge clk);
    #1;
  endtask

  // Outputs must take their reset values asynchronously, before any clock edge.
  task automatic reset_pulse(input string tag);
    rst_n       = 1'b0;
    inst_addr_i = 32'd0;
    #1;
    check_eq({tag, ".rx_ready"},  32'(rx_ready_o),  32'd1);
    check_eq({tag, ".cpu_rst"},   32'(cpu_rst_o),   32'd0);
    check_eq({tag, ".load_done"}, 32'(load_done_o), 32'd0);
    check_eq({tag, ".load_err"},  32'(load_err_o),  32'd0);
    check_eq({tag, ".inst"},      inst_o,           NOP);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n       = 1'b0;
    rx_valid_i  = 1'b0;
    rx_data_i   = 8'h00;
    inst_addr_i = 32'd0;
    #1;
    reset_pulse("reset");

    // Nominal back-to-back load
    img_q = '{32'h0050_0093, 32'h0010_8113};
    send_frame(1'b1, 8'h00, 0, 1'b1);
    sb_push(32'h0001_0000, NOP);
    sb_push(32'h0000_0006, 32'h0010_8113);
    check_status("nominal", 1'b0, 1'b1, 1'b1, 1'b0);

    // DONE lockout: a magic byte offered after DONE must not disturb anything
    rx_valid_i = 1'b1;
    rx_data_i  = 8'hA5;
    repeat (4) begin
      @(negedge clk);
      check_eq("lockout.rx_ready", 32'(rx_ready_o), 32'd0);
      @(posedge clk);
      #1;
    end
    rx_valid_i = 1'b0;
    check_status("lockout", 1'b0, 1'b1, 1'b1, 1'b0);
    drain("nominal");

    // Reset in the middle of a frame, then a fresh three-word image
    reset_pulse("rst0");
    img_q = '{32'hDEAD_BEEF, 32'h1234_5678, 32'hCAFE_F00D};
    send_byte(8'hA5, 0);
    send_byte(8'h03, 0);
    send_byte(8'h00, 0);
    send_byte(8'hEF, 0);
    send_byte(8'hBE, 0);
    send_byte(8'hAD, 0);
    send_byte(8'hDE, 0);
    send_byte(8'h78, 0);
    send_byte(8'h56, 0);
    reset_pulse("rst_mid");
    send_frame(1'b1, 8'h00, 0, 1'b1);
    check_status("reload", 1'b0, 1'b1, 1'b1, 1'b0);
    drain("reload");

    // Noise bytes, random gaps, and a shorter image leaving word 2 untouched
    reset_pulse("rst1");
    send_byte(8'h00, 2);
    send_byte(8'hFF, 2);
    send_byte(8'h5A, 2);
    img_q = '{32'h0050_0093, 32'h0010_8113};
    send_frame(1'b1, 8'h00, 3, 1'b1);
    sb_push(32'h0000_0008, 32'hCAFE_F00D);
    check_status("gaps", 1'b0, 1'b1, 1'b1, 1'b0);
    drain("gaps");

    // Wrong checksum, then recovery
    reset_pulse("rst2");
    send_frame(1'b1, 8'h01, 0, 1'b0);
    check_status("badsum", 1'b1, 1'b0, 1'b0, 1'b1);
    inst_addr_i = 32'd0;
    #1;
    check_eq("badsum.inst", inst_o, NOP);
    @(posedge clk);
    #1;
    send_byte(8'hA5, 0);
    check_eq("recover.err_clear", 32'(load_err_o), 32'd0);
    send_frame(1'b0, 8'h00, 0, 1'b1);
    check_status("recover", 1'b0, 1'b1, 1'b1, 1'b0);
    drain("recover");

    // Illegal word counts
    reset_pulse("rst3");
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    check_eq("n0.err", 32'(load_err_o), 32'd1);
    send_byte(8'hA5, 0);
    check_eq("n0.err_clear", 32'(load_err_o), 32'd0);
    send_byte(8'h01, 0);
    send_byte(8'h10, 0);
    check_eq("n4097.err", 32'(load_err_o), 32'd1);
    check_eq("n4097.cpu_rst", 32'(cpu_rst_o), 32'd0);

    // Stalled frame
    reset_pulse("rst4");
    send_byte(8'hA5, 0);
    send_byte(8'h02, 0);
`ifdef LOADER_TIMEOUT_EN
    repeat (15) begin
      @(posedge clk);
      #1;
    end
    check_eq("tmo.before", 32'(load_err_o), 32'd0);
    @(posedge clk);
    #1;
    check_eq("tmo.hit", 32'(load_err_o), 32'd1);
`else
    repeat (1000) begin
      @(posedge clk);
      #1;
    end
    check_eq("notmo.err", 32'(load_err_o), 32'd0);
    check_eq("notmo.rx_ready", 32'(rx_ready_o), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/inst_rom_loader.md
# inst_rom_loader

Boot-time instruction memory and loader sitting directly upstream of the CPU core's fetch port. It receives a framed program image as a byte stream over a valid/ready handshake and writes it into an internal word-addressed instruction RAM. It then serves the core's instruction fetches combinationally (`inst_addr_o` → `inst_i`). The core is held in reset until a frame loads with a correct checksum.

## Interface
Parameters:
- `DEPTH_LOG2`, 12: log2 of RAM depth in 32-bit words (4096 words, byte range 0x0000–0x3FFF).
- `TIMEOUT_CYCLES`, 100000: inter-byte timeout; only used with `LOADER_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `rx_valid_i`  in  1  byte available.
- `rx_data_i`  in  8  byte value.
- `rx_ready_o`  out  1  loader can accept a byte. A byte transfers on the edge where `rx_valid_i && rx_ready_o`.
- `inst_addr_i`  in  32  fetch byte address, driven from the core's `inst_addr_o`.
- `inst_o`  out  32  fetched instruction, drives the core's `inst_i`; combinational.
- `cpu_rst_o`  out  1  reset to the core; active-low; registered.
- `load_done_o`  out  1  image loaded and verified; registered.
- `load_err_o`  out  1  framing or checksum error; registered.

## Operation
- Frame format (little-endian):
  - magic byte 0xA5;
  - count low byte, count high byte, giving N words;
  - N×4 data bytes, least-significant byte of each word first;
  - one checksum byte equal to the XOR of all data bytes only.
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR. Reset state is IDLE.
- IDLE:
  - 0xA5 → LEN_LO.
  - Any other byte is accepted and discarded.
- LEN_LO: latch the byte as count[7:0] → LEN_HI.
- LEN_HI: latch the byte as count[15:8].
  - N==0 or N>2^DEPTH_LOG2 → ERR.
  - Otherwise → DATA; word index, byte index and checksum accumulator are cleared.
- DATA:
  - Each byte shifts into a word assembly register and is XORed into the accumulator.
  - On the 4th byte, write the assembled word to `mem[word_index]` and increment word_index.
  - After word N-1 is written → CSUM.
- CSUM:
  - Byte == accumulator → DONE.
  - Otherwise → ERR.
- DONE: terminal until reset. `rx_ready_o`=0.
- ERR:
  - `load_err_o`=1 and the core stays in reset.
  - A 0xA5 byte clears `load_err_o` and → LEN_LO.
  - Other bytes are discarded.
- `rx_ready_o`=1 in every state except DONE; it is a combinational decode of the state.
- Read path:
  - `inst_o` = `mem[inst_addr_i[DEPTH_LOG2+1:2]]`.
  - `inst_o` = 0x00000013 (NOP) when `inst_addr_i[31:DEPTH_LOG2+2]` is nonzero or the state is not DONE.
  - `inst_addr_i[1:0]` is ignored.
- RAM contents are not reset. Words at index N and above keep prior contents.

## Timing
- Reset (`rst` low), asynchronously:
  - state IDLE;
  - `cpu_rst_o`=0, `load_done_o`=0, `load_err_o`=0;
  - counters and accumulator cleared;
  - `rx_ready_o`=1, `inst_o`=NOP.
- `rst` asserted mid-frame aborts the frame immediately. RAM words already written remain.
- Write latency: a word is visible in RAM one cycle after its 4th byte is accepted.
- On the edge accepting a correct checksum, state, `load_done_o` and `cpu_rst_o` all become 1 together. The core sees reset released from that cycle on.
- On the edge accepting a wrong checksum or an illegal count, `load_err_o` becomes 1.
- Back-to-back bytes (valid every cycle) are accepted at one byte per cycle with no bubbles.
- Read path has zero cycle latency, matching the core's combinational fetch.

## Configuration
- `LOADER_TIMEOUT_EN` defined:
  - A counter resets on every accepted byte and counts while the state is LEN_LO, LEN_HI, DATA or CSUM.
  - When it reaches `TIMEOUT_CYCLES` with no byte accepted, the FSM → ERR and `load_err_o`=1 on that edge.
  - The counter is idle in IDLE, DONE and ERR.
- `LOADER_TIMEOUT_EN` undefined: no counter logic; the loader waits indefinitely mid-frame.

## Test plan
- Nominal load, one byte per cycle:
  - Stimulus: A5 02 00 93 00 50 00 13 81 10 00 41.
  - Response: `load_done_o`=1, `cpu_rst_o`=1, `inst_o`=0x00500093 at addr 0x0, 0x00108113 at addr 0x4, 0x00000013 at addr 0x10000.
- Wrong checksum, then recovery:
  - Stimulus: the same frame with checksum 0x40.
  - Response: `load_err_o`=1, `cpu_rst_o`=0, `inst_o`=0x00000013.
  - Then resend the correct frame: `load_err_o`=0 after the A5 byte, and it completes as in the nominal case.
- Noise and illegal counts:
  - Bytes 00 FF 5A before the frame are ignored, and the frame loads normally.
  - A5 00 00 → ERR.
  - A5 01 10 (N=4097) → ERR.
- Stalls and reset mid-frame:
  - Stimulus: random gaps on `rx_valid_i`.
  - Response: the same result as the nominal case.
  - `rst` pulsed low after 6 data bytes → outputs return to reset values immediately, and a fresh full frame then loads.
- DONE lockout:
  - After DONE, `rx_ready_o`=0.
  - Asserting `rx_valid_i` with 0xA5 changes neither the state nor the RAM.
- Timeout (with `LOADER_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16):
  - Stimulus: send A5 02, then idle.
  - Response: `load_err_o` rises 16 cycles after the last byte was accepted.
  - Without the macro, no error after 1000 idle cycles.
